// File: rtl/wd_reg_access.sv
// Sequencer for CPU accesses to WD33C93 registers: chip select, read/write strobes
// and data-bus enable with programmable setup/strobe/hold, plus active-low cycle termination.
module wd_reg_access #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic       nCPUCLK,
    input  logic       _RST,
    input  logic       AS_,
    input  logic       DMAC_,
    input  logic       WDREGREQ,
    input  logic       R_W,
    input  logic [7:0] DIN,
    input  logic [7:0] PD_IN,
    output logic       SCSI_CS_,
    output logic       SCSI_RE_,
    output logic       SCSI_WE_,
    output logic [7:0] PD_OUT,
    output logic       PD_OE,
    output logic [7:0] DOUT,
    output logic       DOUT_OE,
    output logic       WD_DSK_,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        TERM   = 3'd4
    } state_t;

    localparam logic [2:0] SETUP_LD  = 3'(SETUP_CYC - 1);
    localparam logic [2:0] STROBE_LD = 3'(STROBE_CYC - 1);
    localparam logic [2:0] HOLD_LD   = 3'(HOLD_CYC - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       dir, dir_nxt;
    logic       aborting, aborting_nxt;
    logic       capture;
    logic       start;
    logic       timed;
    logic       busy_nxt;

    assign start     = (state == IDLE) & ~AS_ & ~DMAC_ & WDREGREQ;
    assign timed     = (state == SETUP) | (state == STROBE) | (state == HOLD);
    assign busy_nxt  = (state_nxt == SETUP) | (state_nxt == STROBE) | (state_nxt == HOLD);
    assign dbg_state = state;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dir_nxt      = dir;
        aborting_nxt = aborting;
        capture      = 1'b0;
        if (start) begin
            state_nxt    = SETUP;
            cnt_nxt      = SETUP_LD;
            dir_nxt      = R_W;
            aborting_nxt = 1'b0;
        end else if (timed) begin
            // Once aborting, AS_ is ignored so a held-high AS_ cannot stretch HOLD forever.
            if (AS_ && !aborting) begin
                state_nxt    = HOLD;
                cnt_nxt      = HOLD_LD;
                aborting_nxt = 1'b1;
            end else if (cnt != 3'd0) begin
                cnt_nxt = cnt - 3'd1;
            end else begin
                case (state)
                    SETUP: begin
                        state_nxt = STROBE;
                        cnt_nxt   = STROBE_LD;
                    end
                    STROBE: begin
                        state_nxt = HOLD;
                        cnt_nxt   = HOLD_LD;
                        capture   = dir;
                    end
                    default: begin
                        state_nxt    = aborting ? IDLE : TERM;
                        cnt_nxt      = 3'd0;
                        aborting_nxt = 1'b0;
                    end
                endcase
            end
        end else if (state == TERM) begin
            if (AS_) state_nxt = IDLE;
        end
    end

    // Every output is a registered function of the next state, so pins change on the same edge as the FSM.
    always_ff @(posedge nCPUCLK) begin
        if (!_RST) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            dir      <= 1'b0;
            aborting <= 1'b0;
            SCSI_CS_ <= 1'b1;
            SCSI_RE_ <= 1'b1;
            SCSI_WE_ <= 1'b1;
            WD_DSK_  <= 1'b1;
            PD_OE    <= 1'b0;
            DOUT_OE  <= 1'b0;
            PD_OUT   <= 8'h00;
            DOUT     <= 8'h00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dir      <= dir_nxt;
            aborting <= aborting_nxt;
            SCSI_CS_ <= ~busy_nxt;
            SCSI_RE_ <= ~((state_nxt == STROBE) & dir_nxt);
            SCSI_WE_ <= ~((state_nxt == STROBE) & ~dir_nxt);
            WD_DSK_  <= ~(state_nxt == TERM);
            PD_OE    <= busy_nxt & ~dir_nxt;
            DOUT_OE  <= (state_nxt == TERM) & dir_nxt;
            if (start && !R_W) PD_OUT <= DIN;
            if (capture) DOUT <= PD_IN;
        end
    end

endmodule
